// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and publishes diff/bout/ovf with a one-cycle done pulse on completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    // Full-subtractor cell on the current LSB; result bits enter at the MSB
    assign a_bit = a_q[0];
    assign b_bit = b_q[0];
    assign d_bit = a_bit ^ b_bit ^ br_q;
    assign br_d  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    assign res_d = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    // ovf compares the borrow into the MSB with the borrow out of it
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        ovf_q   <= br_q ^ br_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances checked every cycle
// against an arithmetic reference model, plus directed literal scenarios.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       bin1 = 1'b0;
    logic       busy1, done1, bout1, ovf1;
    logic [0:0] diff1;

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Plain-arithmetic reference: modular difference, unsigned borrow, signed range overflow
    function automatic void ref_sub(input int w, input longint unsigned a, input longint unsigned b,
                                    input bit bi, output longint unsigned d, output bit bo, output bit ov);
        longint unsigned m;
        longint sa, sb, r, lo, hi;
        m  = (64'd1 << w) - 64'd1;
        d  = (a - b - 64'(bi)) & m;
        bo = (a < b + 64'(bi));
        sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        r  = sa - sb - longint'(bi);
        hi = longint'(64'd1 << (w - 1)) - 1;
        lo = -longint'(64'd1 << (w - 1));
        ov = (r < lo) || (r > hi);
    endfunction

    // Cycle-level model for the WIDTH=8 instance
    int              rem8 = 0;
    longint unsigned pd8;
    bit              pb8, po8;
    bit              ed8 = 1'b0, eb8 = 1'b0, eo8 = 1'b0;
    logic [7:0]      ediff8 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem8 = 0; ed8 = 1'b0; eb8 = 1'b0; eo8 = 1'b0; ediff8 = '0;
        end else begin
            ed8 = 1'b0;
            if (rem8 > 0) begin
                rem8--;
                if (rem8 == 0) begin
                    ed8 = 1'b1; ediff8 = 8'(pd8); eb8 = pb8; eo8 = po8;
                end
            end else if (start8) begin
                ref_sub(8, 64'(a8), 64'(b8), bin8, pd8, pb8, po8);
                rem8 = 8;
            end
        end
    end

    // Cycle-level model for the WIDTH=1 instance
    int              rem1 = 0;
    longint unsigned pd1;
    bit              pb1, po1;
    bit              ed1 = 1'b0, eb1 = 1'b0, eo1 = 1'b0;
    logic [0:0]      ediff1 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem1 = 0; ed1 = 1'b0; eb1 = 1'b0; eo1 = 1'b0; ediff1 = '0;
        end else begin
            ed1 = 1'b0;
            if (rem1 > 0) begin
                rem1--;
                if (rem1 == 0) begin
                    ed1 = 1'b1; ediff1 = 1'(pd1); eb1 = pb1; eo1 = po1;
                end
            end else if (start1) begin
                ref_sub(1, 64'(a1), 64'(b1), bin1, pd1, pb1, po1);
                rem1 = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy8", 64'(busy8), 64'(rem8 > 0));
        chk("cyc_done8", 64'(done8), 64'(ed8));
        chk("cyc_diff8", 64'(diff8), 64'(ediff8));
        chk("cyc_bout8", 64'(bout8), 64'(eb8));
        chk("cyc_ovf8",  64'(ovf8),  64'(eo8));
        chk("cyc_busy1", 64'(busy1), 64'(rem1 > 0));
        chk("cyc_done1", 64'(done1), 64'(ed1));
        chk("cyc_diff1", 64'(diff1), 64'(ediff1));
        chk("cyc_bout1", 64'(bout1), 64'(eb1));
        chk("cyc_ovf1",  64'(ovf1),  64'(eo1));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int lat);
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (done8 === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chk_zero8(input string nm);
        chk({nm, "_busy"}, 64'(busy8), 64'd0);
        chk({nm, "_done"}, 64'(done8), 64'd0);
        chk({nm, "_diff"}, 64'(diff8), 64'd0);
        chk({nm, "_bout"}, 64'(bout8), 64'd0);
        chk({nm, "_ovf"},  64'(ovf8),  64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ndone, k;
        longint unsigned md;
        bit mb, mo;
        logic [7:0] va [3], vb [3], vd [3];
        logic       vbi [3], vbo [3], vov [3];
        int         t [2];
        logic [7:0] dd [2];
        logic       bb [2];
        logic [7:0] tbl_d, tbl_b;
        logic [2:0] combo;

        // Model pinned against hand-computed values
        ref_sub(8, 64'h05, 64'h03, 1'b0, md, mb, mo);
        chk("model_05_03", {md[61:0], mb, mo}, {62'h02, 1'b0, 1'b0});
        ref_sub(8, 64'h80, 64'h01, 1'b0, md, mb, mo);
        chk("model_80_01", {md[61:0], mb, mo}, {62'h7F, 1'b0, 1'b1});
        ref_sub(8, 64'h7F, 64'hFF, 1'b0, md, mb, mo);
        chk("model_7F_FF", {md[61:0], mb, mo}, {62'h80, 1'b1, 1'b1});

        #2 rst_n = 1'b0;
        #1 chk_zero8("reset8");
        chk("reset1_busy", 64'(busy1), 64'd0);
        chk("reset1_done", 64'(done1), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Basic 5 - 3
        op8(8'h05, 8'h03, 1'b0, lat);
        chk("basic_lat", 64'(lat), 64'd8);
        chk("basic_diff", 64'(diff8), 64'h02);
        chk("basic_bout", 64'(bout8), 64'd0);
        chk("basic_ovf",  64'(ovf8),  64'd0);

        va = '{8'h00, 8'h80, 8'h10}; vb = '{8'h01, 8'h01, 8'h10}; vbi = '{1'b0, 1'b0, 1'b1};
        vd = '{8'hFF, 8'h7F, 8'hFF}; vbo = '{1'b1, 1'b0, 1'b1}; vov = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            op8(va[i], vb[i], vbi[i], lat);
            chk($sformatf("vec%0d_lat", i),  64'(lat),   64'd8);
            chk($sformatf("vec%0d_diff", i), 64'(diff8), 64'(vd[i]));
            chk($sformatf("vec%0d_bout", i), 64'(bout8), 64'(vbo[i]));
            chk($sformatf("vec%0d_ovf", i),  64'(ovf8),  64'(vov[i]));
        end
        cyc();

        // Start during SHIFT is ignored
        a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        cyc(); cyc();
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done8 === 1'b1) begin
                ndone++;
                chk("ignore_diff", 64'(diff8), 64'h02);
            end
        end
        chk("ignore_ndone", 64'(ndone), 64'd1);

        // Async reset mid-operation, then restart immediately after release
        a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        repeat (4) cyc();
        #2 rst_n = 1'b0;
        #1 chk_zero8("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op8(8'h09, 8'h04, 1'b0, lat);
        chk("rst_restart_lat",  64'(lat),   64'd8);
        chk("rst_restart_diff", 64'(diff8), 64'h05);
        cyc();

        // Back-to-back with start held high
        a8 = 8'h20; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        cyc();
        a8 = 8'h01; b8 = 8'h02;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (done8 === 1'b1) begin
                t[k] = i; dd[k] = diff8; bb[k] = bout8;
                k++;
                if (k == 2) break;
            end
        end
        start8 = 1'b0;
        chk("b2b_count", 64'(k), 64'd2);
        if (k == 2) begin
            chk("b2b_t0", 64'(t[0]), 64'd8);
            chk("b2b_period", 64'(t[1] - t[0]), 64'd9);
            chk("b2b_d0", 64'(dd[0]), 64'h1F);
            chk("b2b_b0", 64'(bb[0]), 64'd0);
            chk("b2b_d1", 64'(dd[1]), 64'hFF);
            chk("b2b_b1", 64'(bb[1]), 64'd1);
        end
        cyc();

        // WIDTH=1 full-subtractor truth table, index = {a,b,bin}
        tbl_d = 8'b1001_0110;
        tbl_b = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            a1 = combo[2]; b1 = combo[1]; bin1 = combo[0]; start1 = 1'b1;
            cyc();
            start1 = 1'b0;
            cyc();
            chk($sformatf("w1_done_%0d", i), 64'(done1), 64'd1);
            chk($sformatf("w1_diff_%0d", i), 64'(diff1), 64'(tbl_d[i]));
            chk($sformatf("w1_bout_%0d", i), 64'(bout1), 64'(tbl_b[i]));
        end
        cyc();

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            start8 = ($urandom_range(0, 3) != 0);
            a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
            start1 = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            cyc();
        end
        start8 = 1'b0; start1 = 1'b0;
        repeat (12) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
